// File: rtl/boot_rom_checker.sv
// TCDM read initiator that scans a word region and folds it into a 32-bit signature.
// Define BOOT_ROM_CHECKER_CRC32_EN for an IEEE CRC-32 signature; default is a modular word sum.
module boot_rom_checker #(
  parameter int unsigned NWORDS_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [NWORDS_WIDTH-1:0] num_words_i,
  input  logic [31:0]             expected_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o,
  output logic [31:0]             signature_o,
  output logic                    tcdm_req_o,
  output logic [31:0]             tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [31:0]             tcdm_wdata_o,
  output logic [3:0]              tcdm_be_o,
  input  logic                    tcdm_gnt_i,
  input  logic [31:0]             tcdm_r_rdata_i,
  input  logic                    tcdm_r_valid_i
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [NWORDS_WIDTH-1:0] LastWord = NWORDS_WIDTH'(1);

`ifdef BOOT_ROM_CHECKER_CRC32_EN
  localparam logic [31:0] SigInit = 32'hFFFF_FFFF;
  localparam logic [31:0] SigXor  = 32'hFFFF_FFFF;

  // Reflected CRC: the four little-endian bytes are consumed LSB first, i.e. word bit 0 first.
  function automatic logic [31:0] sig_fold(input logic [31:0] acc, input logic [31:0] word);
    logic [31:0] c;
    c = acc ^ word;
    for (int i = 0; i < 32; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction
`else
  localparam logic [31:0] SigInit = 32'h0000_0000;
  localparam logic [31:0] SigXor  = 32'h0000_0000;

  function automatic logic [31:0] sig_fold(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction
`endif

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             addr_q, addr_d;
  logic [NWORDS_WIDTH-1:0] left_q, left_d;
  logic [31:0]             exp_q, exp_d;
  logic [31:0]             sig_q, sig_d;
  logic                    req_q, req_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    tmo_q, tmo_d;
  logic [TmoW-1:0]         tcnt_q, tcnt_d;

  logic [31:0] sig_next;
  logic        timer_hit;

  assign sig_next  = sig_fold(sig_q, tcdm_r_rdata_i);
  assign timer_hit = (tcnt_q == TmoLast);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a grant or response in the same cycle as the timer expiring wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = (num_words_i == '0) ? StDone : StReq;
        end
      end
      StReq: begin
        if (tcdm_gnt_i) begin
          state_d = StWait;
        end else if (timer_hit) begin
          state_d = StDone;
        end
      end
      StWait: begin
        if (tcdm_r_valid_i) begin
          state_d = (left_q == LastWord) ? StDone : StReq;
        end else if (timer_hit) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    addr_d = addr_q;
    left_d = left_q;
    exp_d  = exp_q;
    sig_d  = sig_q;
    req_d  = req_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    tmo_d  = tmo_q;
    tcnt_d = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          addr_d = base_addr_i & 32'hFFFF_FFFC;
          left_d = num_words_i;
          exp_d  = expected_i;
          sig_d  = SigInit;
          tmo_d  = 1'b0;
          if (num_words_i == '0) begin
            req_d  = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = ((SigInit ^ SigXor) == expected_i);
          end else begin
            req_d  = 1'b1;
            busy_d = 1'b1;
            done_d = 1'b0;
            pass_d = 1'b0;
          end
        end
      end
      StReq: begin
        tcnt_d = tcnt_q + TmoW'(1);
        if (tcdm_gnt_i) begin
          req_d  = 1'b0;
          tcnt_d = '0;
        end else if (timer_hit) begin
          req_d  = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
          tmo_d  = 1'b1;
          pass_d = 1'b0;
        end
      end
      StWait: begin
        tcnt_d = tcnt_q + TmoW'(1);
        if (tcdm_r_valid_i) begin
          tcnt_d = '0;
          sig_d  = sig_next;
          left_d = left_q - LastWord;
          if (left_q == LastWord) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = ((sig_next ^ SigXor) == exp_q);
          end else begin
            addr_d = addr_q + 32'd4;
            req_d  = 1'b1;
          end
        end else if (timer_hit) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          tmo_d  = 1'b1;
          pass_d = 1'b0;
        end
      end
      default: begin
        req_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      left_q <= '0;
      exp_q  <= '0;
      sig_q  <= SigInit;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tmo_q  <= 1'b0;
      tcnt_q <= '0;
    end else begin
      addr_q <= addr_d;
      left_q <= left_d;
      exp_q  <= exp_d;
      sig_q  <= sig_d;
      req_q  <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      tmo_q  <= tmo_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign timeout_o    = tmo_q;
  assign signature_o  = sig_q ^ SigXor;
  assign tcdm_req_o   = req_q;
  assign tcdm_add_o   = addr_q;
  assign tcdm_wen_o   = 1'b1;
  assign tcdm_wdata_o = 32'h0;
  assign tcdm_be_o    = 4'hF;

endmodule

// File: tb/tb_boot_rom_checker.sv
// Randomized bench for boot_rom_checker: the bench plays the TCDM target and compares against
// a signature model computed directly from the word list.
module tb_boot_rom_checker;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] num_words_i;
  logic [31:0] expected_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [31:0] signature_o;
  logic        tcdm_req_o, tcdm_wen_o;
  logic [31:0] tcdm_add_o, tcdm_wdata_o;
  logic [3:0]  tcdm_be_o;
  logic        tcdm_gnt_i, tcdm_r_valid_i;
  logic [31:0] tcdm_r_rdata_i;

  boot_rom_checker #(
    .NWORDS_WIDTH  (16),
    .TIMEOUT_CYCLES(256)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_words_i   (num_words_i),
    .expected_i    (expected_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .timeout_o     (timeout_o),
    .signature_o   (signature_o),
    .tcdm_req_o    (tcdm_req_o),
    .tcdm_add_o    (tcdm_add_o),
    .tcdm_wen_o    (tcdm_wen_o),
    .tcdm_wdata_o  (tcdm_wdata_o),
    .tcdm_be_o     (tcdm_be_o),
    .tcdm_gnt_i    (tcdm_gnt_i),
    .tcdm_r_rdata_i(tcdm_r_rdata_i),
    .tcdm_r_valid_i(tcdm_r_valid_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  logic [31:0] data_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // Signature of the first n words of data_q
  function automatic logic [31:0] model_sig(input int n);
    logic [31:0] c;
`ifdef BOOT_ROM_CHECKER_CRC32_EN
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) begin
        c = c ^ {24'h0, data_q[k][8*b +: 8]};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
`else
    c = 32'h0;
    for (int k = 0; k < n; k++) c = c + data_q[k];
    return c;
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_pass"}, pass_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_req"}, tcdm_req_o, 0);
    check({tag, "_add"}, tcdm_add_o, 0);
    check({tag, "_sig"}, signature_o, model_sig(0));
  endtask

  task automatic fill_random(input int n);
    data_q.delete();
    for (int k = 0; k < n; k++) data_q.push_back($urandom);
  endtask

  // One complete scan; the bench answers each request after gd/rd cycles.
  task automatic run_scan(input logic [31:0] base, input int n, input logic [31:0] expected,
                          input int gd_max, input int rd_max, input bit rand_delay,
                          input bit poke, input int exp_cycles);
    logic [31:0] exp_addr, exp_sig;
    int t0, gd, rd;
    exp_sig     = model_sig(n);
    exp_addr    = {base[31:2], 2'b00};
    base_addr_i = base;
    num_words_i = 16'(n);
    expected_i  = expected;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    t0      = int'(cyc) - 1;
    if (n > 0) check("busy_after_start", busy_o, 1);
    for (int k = 0; k < n; k++) begin
      check("req_issued", tcdm_req_o, 1);
      check("req_addr", tcdm_add_o, exp_addr);
      gd = rand_delay ? int'($urandom_range(gd_max, 0)) : gd_max;
      rd = rand_delay ? int'($urandom_range(rd_max, 0)) : rd_max;
      repeat (gd) begin
        if (poke) begin
          start_i        = 1'b1;
          base_addr_i    = $urandom;
          num_words_i    = 16'($urandom_range(5, 0));
          expected_i     = $urandom;
          tcdm_r_valid_i = 1'b1;
          tcdm_r_rdata_i = $urandom;
        end
        step();
        start_i        = 1'b0;
        tcdm_r_valid_i = 1'b0;
        check("req_held", tcdm_req_o, 1);
        check("addr_held", tcdm_add_o, exp_addr);
      end
      tcdm_gnt_i = 1'b1;
      step();
      tcdm_gnt_i = 1'b0;
      check("req_drop", tcdm_req_o, 0);
      repeat (rd) begin
        step();
        check("no_extra_req", tcdm_req_o, 0);
      end
      tcdm_r_rdata_i = data_q[k];
      tcdm_r_valid_i = 1'b1;
      step();
      tcdm_r_valid_i = 1'b0;
      tcdm_r_rdata_i = $urandom;
      exp_addr       = exp_addr + 32'd4;
    end
    check("done", done_o, 1);
    check("busy_end", busy_o, 0);
    check("timeout_end", timeout_o, 0);
    check("req_end", tcdm_req_o, 0);
    check("signature", signature_o, exp_sig);
    check("pass", pass_o, (exp_sig == expected) ? 32'd1 : 32'd0);
    if (exp_cycles > 0) check("done_cycle", int'(cyc) - t0, exp_cycles);
    if (poke) begin
      tcdm_r_valid_i = 1'b1;
      step();
      tcdm_r_valid_i = 1'b0;
      check("stray_rvalid_sig", signature_o, exp_sig);
      check("done_held", done_o, 1);
    end
  endtask

  initial begin
    logic [31:0] e;
    int hi;
    rst_ni         = 1'b0;
    start_i        = 1'b0;
    base_addr_i    = '0;
    num_words_i    = '0;
    expected_i     = '0;
    tcdm_gnt_i     = 1'b0;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_rdata_i = '0;
    data_q.delete();
    step();
    step();
    check_reset_vals("reset");
    check("wen_const", tcdm_wen_o, 1);
    check("wdata_const", tcdm_wdata_o, 0);
    check("be_const", tcdm_be_o, 32'hF);
    rst_ni = 1'b1;
    step();

    // Zero-wait four-word scan
    data_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_scan(32'h1A00_0000, 4, 32'd10, 0, 0, 1'b0, 1'b0, 9);

    // Single zero word, matching then mismatching reference
    data_q = '{32'h0};
`ifdef BOOT_ROM_CHECKER_CRC32_EN
    run_scan(32'h1A00_0100, 1, 32'h2144_DF1C, 0, 0, 1'b0, 1'b0, 3);
    check("crc_zero_word", signature_o, 32'h2144_DF1C);
`else
    run_scan(32'h1A00_0100, 1, 32'h0, 0, 0, 1'b0, 1'b0, 3);
`endif
    run_scan(32'h1A00_0100, 1, 32'h0, 0, 0, 1'b0, 1'b0, 3);
    run_scan(32'h1A00_0100, 1, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 3);

    // Slow target: grant after 5 cycles, response 3 cycles later
    fill_random(3);
    run_scan(32'h1A00_0200, 3, model_sig(3), 5, 3, 1'b0, 1'b0, 0);

    // Empty region completes one cycle after start
    run_scan(32'h1A00_0300, 0, model_sig(0), 0, 0, 1'b0, 1'b0, 1);
    run_scan(32'h1A00_0300, 0, 32'hCAFE_0001, 0, 0, 1'b0, 1'b0, 1);

    // Address wrap and unaligned base
    fill_random(2);
    run_scan(32'hFFFF_FFFC, 2, model_sig(2), 1, 1, 1'b1, 1'b0, 0);
    fill_random(2);
    run_scan(32'h1A00_0403, 2, $urandom, 1, 1, 1'b1, 1'b0, 0);

    // Grant never arrives
    fill_random(2);
    base_addr_i = 32'h1A00_0500;
    num_words_i = 16'd2;
    expected_i  = model_sig(0);
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    hi      = 0;
    while (tcdm_req_o && hi < 400) begin
      hi++;
      step();
    end
    check("req_timeout_len", hi, 256);
    check("req_tmo_done", done_o, 1);
    check("req_tmo_flag", timeout_o, 1);
    check("req_tmo_pass", pass_o, 0);
    check("req_tmo_busy", busy_o, 0);
    check("req_tmo_sig", signature_o, model_sig(0));

    // Response never arrives for the second word
    fill_random(3);
    base_addr_i = 32'h1A00_0600;
    num_words_i = 16'd3;
    expected_i  = model_sig(3);
    start_i     = 1'b1;
    step();
    start_i    = 1'b0;
    tcdm_gnt_i = 1'b1;
    step();
    tcdm_gnt_i     = 1'b0;
    tcdm_r_rdata_i = data_q[0];
    tcdm_r_valid_i = 1'b1;
    step();
    tcdm_r_valid_i = 1'b0;
    check("wait_tmo_req2", tcdm_req_o, 1);
    check("wait_tmo_clear", timeout_o, 0);
    tcdm_gnt_i = 1'b1;
    step();
    tcdm_gnt_i = 1'b0;
    hi         = 0;
    while (busy_o && hi < 400) begin
      hi++;
      step();
    end
    check("wait_timeout_len", hi, 256);
    check("wait_tmo_flag", timeout_o, 1);
    check("wait_tmo_pass", pass_o, 0);
    check("wait_tmo_partial", signature_o, model_sig(1));
    check("wait_tmo_req", tcdm_req_o, 0);

    // Reset in WAIT, then a late response
    fill_random(2);
    base_addr_i = 32'h1A00_0700;
    num_words_i = 16'd2;
    expected_i  = model_sig(2);
    start_i     = 1'b1;
    step();
    start_i    = 1'b0;
    tcdm_gnt_i = 1'b1;
    step();
    tcdm_gnt_i = 1'b0;
    rst_ni     = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    rst_ni         = 1'b1;
    tcdm_r_rdata_i = 32'h5A5A_5A5A;
    tcdm_r_valid_i = 1'b1;
    step();
    tcdm_r_valid_i = 1'b0;
    step();
    check_reset_vals("late_rvalid");

    // Randomized scans with busy-time start pulses and stray responses
    for (int t = 0; t < 25; t++) begin
      int n;
      n = int'($urandom_range(6, 0));
      fill_random(n);
      e = ($urandom_range(1, 0) == 1) ? model_sig(n) : $urandom;
      run_scan($urandom, n, e, 3, 3, 1'b1, 1'b1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
